// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The byte-lane helper picks one little-endian byte out of a requester word.
package dmem_arb_pkg;

    localparam int ARB_ADDR_W = 5;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_BYTE_W = 8;
    localparam int BEATS      = 4;

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TAIL = 2'd2,
        ACK  = 2'd3
    } arb_state_e;

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-requester round-robin picker: a lone requester wins, a tie goes to
// whichever port did not own the memory last.
import dmem_arb_pkg::*;

module rr_arbiter2 (
    input  logic i_req_cpu,
    input  logic i_req_host,
    input  logic i_last_owner,
    output logic o_valid,
    output logic o_owner
);

    // Grant selection
    always_comb begin
        o_valid = i_req_cpu | i_req_host;
        if (i_req_cpu && i_req_host) begin
            o_owner = ~i_last_owner;
        end else if (i_req_host) begin
            o_owner = OWN_HOST;
        end else begin
            o_owner = OWN_CPU;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the byte-wide data memory between the CPU and host ports and
// sequences each granted word as four little-endian byte beats, then acks.
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int BYTE_W = ARB_BYTE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cpu_req_i,
    input  logic              host_req_i,
    input  logic              cpu_we_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              cpu_ack_o,
    output logic              host_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [BYTE_W-1:0] mem_wdata_o,
    input  logic [BYTE_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              owner_o
);

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic [1:0]              r_beat;
    logic [1:0]              w_beat_inc;

    logic                    r_we;
    logic [ADDR_W-3:0]       r_addr_hi;
    logic [DATA_W-1:0]       r_wdata;
    logic                    r_owner;
    logic [DATA_W-BYTE_W-1:0] r_shift;

    logic                    r_mem_en;
    logic                    r_mem_we;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [BYTE_W-1:0]       r_mem_wdata;
    logic                    r_cpu_ack;
    logic                    r_host_ack;
    logic [DATA_W-1:0]       r_cpu_rdata;
    logic [DATA_W-1:0]       r_host_rdata;
    logic                    r_busy;

    logic                    w_grant_valid;
    logic                    w_grant_owner;
    logic                    w_grant;
    logic                    w_win_we;
    logic [ADDR_W-1:0]       w_win_addr;
    logic [DATA_W-1:0]       w_win_wdata;
    logic                    w_addr_unused;
    logic                    w_capture;

    logic                    w_mem_en_nxt;
    logic                    w_mem_we_nxt;
    logic [ADDR_W-1:0]       w_mem_addr_nxt;
    logic [BYTE_W-1:0]       w_mem_wdata_nxt;
    logic                    w_cpu_ack_nxt;
    logic                    w_host_ack_nxt;

    rr_arbiter2 u_rr (
        .i_req_cpu    (cpu_req_i),
        .i_req_host   (host_req_i),
        .i_last_owner (r_owner),
        .o_valid      (w_grant_valid),
        .o_owner      (w_grant_owner)
    );

    assign w_grant       = (r_state == IDLE) && start_i && w_grant_valid;
    assign w_beat_inc    = r_beat + 2'd1;
    assign w_addr_unused = ^w_win_addr[1:0];
    // Byte k arrives one cycle after its strobe: beats 1-3 carry bytes 0-2, TAIL carries byte 3.
    assign w_capture     = ((r_state == XFER) && (r_beat != 2'd0)) || (r_state == TAIL);

    // Winning requester's command, selected by the arbiter
    always_comb begin
        if (w_grant_owner == OWN_HOST) begin
            w_win_we    = host_we_i;
            w_win_addr  = host_addr_i;
            w_win_wdata = host_wdata_i;
        end else begin
            w_win_we    = cpu_we_i;
            w_win_addr  = cpu_addr_i;
            w_win_wdata = cpu_wdata_i;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_grant ? XFER : IDLE;
            XFER:    w_state_nxt = (r_beat == 2'd3) ? TAIL : XFER;
            TAIL:    w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM output logic: values the output registers take on the next edge
    always_comb begin
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = {ADDR_W{1'b0}};
        w_mem_wdata_nxt = {BYTE_W{1'b0}};
        w_cpu_ack_nxt   = 1'b0;
        w_host_ack_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = w_win_we;
                    w_mem_addr_nxt  = {w_win_addr[ADDR_W-1:2], 2'd0};
                    w_mem_wdata_nxt = byte_of(w_win_wdata, 2'd0);
                end else begin
                    w_mem_en_nxt    = 1'b0;
                end
            end
            XFER: begin
                if (r_beat != 2'd3) begin
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = r_we;
                    w_mem_addr_nxt  = {r_addr_hi, w_beat_inc};
                    w_mem_wdata_nxt = byte_of(r_wdata, w_beat_inc);
                end else begin
                    w_mem_en_nxt    = 1'b0;
                end
            end
            TAIL: begin
                if (r_owner == OWN_HOST) begin
                    w_host_ack_nxt = 1'b1;
                end else begin
                    w_cpu_ack_nxt  = 1'b1;
                end
            end
            ACK:     w_mem_en_nxt = 1'b0;
            default: w_mem_en_nxt = 1'b0;
        endcase
    end

    // Beat counter, restarted on every grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_beat <= 2'd0;
        end else if (w_grant) begin
            r_beat <= 2'd0;
        end else if (r_state == XFER) begin
            r_beat <= w_beat_inc;
        end else begin
            r_beat <= r_beat;
        end
    end

    // Command latches, read shift register and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we         <= 1'b0;
            r_addr_hi    <= {(ADDR_W-2){1'b0}};
            r_wdata      <= {DATA_W{1'b0}};
            r_owner      <= OWN_HOST;
            r_shift      <= {(DATA_W-BYTE_W){1'b0}};
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {ADDR_W{1'b0}};
            r_mem_wdata  <= {BYTE_W{1'b0}};
            r_cpu_ack    <= 1'b0;
            r_host_ack   <= 1'b0;
            r_cpu_rdata  <= {DATA_W{1'b0}};
            r_host_rdata <= {DATA_W{1'b0}};
            r_busy       <= 1'b0;
        end else begin
            if (w_grant) begin
                r_we      <= w_win_we;
                r_addr_hi <= w_win_addr[ADDR_W-1:2];
                r_wdata   <= w_win_wdata;
                r_owner   <= w_grant_owner;
            end
            if (w_capture) begin
                r_shift <= {mem_rdata_i, r_shift[DATA_W-BYTE_W-1:BYTE_W]};
            end
            if ((r_state == TAIL) && !r_we) begin
                if (r_owner == OWN_HOST) begin
                    r_host_rdata <= {mem_rdata_i, r_shift};
                end else begin
                    r_cpu_rdata  <= {mem_rdata_i, r_shift};
                end
            end
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_cpu_ack   <= w_cpu_ack_nxt;
            r_host_ack  <= w_host_ack_nxt;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign cpu_ack_o    = r_cpu_ack;
    assign host_ack_o   = r_host_ack;
    assign cpu_rdata_o  = r_cpu_rdata;
    assign host_rdata_o = r_host_rdata;
    assign mem_en_o     = r_mem_en;
    assign mem_we_o     = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wdata_o  = r_mem_wdata;
    assign busy_o       = r_busy;
    assign owner_o      = r_owner;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single byte-wide data memory between the CPU load/store port and a host loader/debug port, replacing direct hierarchical pokes of data memory. Each granted 32-bit word access is sequenced as four little-endian byte beats on the memory port, then acknowledged to the owner. Sits between `CPU`'s memory stage, the host interface and `Data_Memory`.

## Interface
- `ADDR_W`, 5: byte address width; 32-byte memory.
- `DATA_W`, 32: requester word width.
- `BYTE_W`, 8: memory port width.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  grant enable; low blocks new grants, in-flight access completes.
- `cpu_req_i`, `host_req_i`  in  1  access request, held until ack.
- `cpu_we_i`, `host_we_i`  in  1  1 = write word, 0 = read word.
- `cpu_addr_i`, `host_addr_i`  in  ADDR_W  byte address; bits [1:0] ignored.
- `cpu_wdata_i`, `host_wdata_i`  in  DATA_W  write word.
- `cpu_ack_o`, `host_ack_o`  out  1  one-cycle completion pulse.
- `cpu_rdata_o`, `host_rdata_o`  out  DATA_W  read word, valid with ack, held until next ack to that port.
- `mem_en_o`  out  1  byte access strobe.
- `mem_we_o`  out  1  byte write.
- `mem_addr_o`  out  ADDR_W  byte address.
- `mem_wdata_o`  out  BYTE_W  byte write data.
- `mem_rdata_i`  in  BYTE_W  byte read data, valid the cycle after a read strobe.
- `busy_o`  out  1  access in flight (any state but IDLE).
- `owner_o`  out  1  0 = CPU, 1 = host; current/last owner.

## Operation
- FSM: IDLE -> XFER (4 beats) -> TAIL -> ACK -> IDLE.
- IDLE: if `start_i` and any req, grant, latch we/addr/wdata of winner, go XFER. Otherwise stay.
- Arbitration: single requester wins. Both requesting: winner is the port that is not `owner_o` (round-robin). Reset `owner_o`=1 so CPU wins first tie.
- XFER beat k (k=0..3): `mem_en_o`=1, `mem_we_o`=latched we, `mem_addr_o`={addr[4:2], k[1:0]}, `mem_wdata_o`=wdata[8k+7:8k].
- Read capture: byte k loaded into rdata shift register in the cycle after beat k (beats 1-3 of XFER, then TAIL).
- TAIL: no strobe; last byte captured.
- ACK: owner's ack=1; owner's rdata_o updated (reads only; writes leave it unchanged). Go IDLE.
- Requests are re-sampled in IDLE: requester deasserts req the cycle after ack or is served again.
- Latched values make requester changes after grant harmless; stability is still required by protocol.
- Reset mid-access: return to IDLE next edge; bytes already written remain, no ack issued.
- Reset values: all mem_* outputs 0, both acks 0, both rdata 0, `busy_o`=0, `owner_o`=1, state IDLE.

## Timing
- Cycle 0: IDLE sees req -> cycles 1-4 XFER beats 0-3 -> cycle 5 TAIL -> cycle 6 ACK -> cycle 7 IDLE.
- Fixed latency: ack 6 cycles after the grant cycle, read and write alike.
- Max throughput: one word per 7 cycles; continuously contending ports alternate.
- All outputs registered; no combinational path from `mem_rdata_i` or any req to outputs.
- `start_i` low at cycle 0 delays grant; low during XFER/TAIL/ACK has no effect.

## Structure
- Package `dmem_arb_pkg`: state enum (IDLE, XFER, TAIL, ACK), owner constants OWN_CPU=0 / OWN_HOST=1, BEATS=4.
- Sub-module `rr_arbiter2`: two-request round-robin picker (req pair + last owner -> grant), combinational, instantiated once.
- Top: FSM, beat counter (2 bits), latch registers, read shift register, ack/rdata output registers.

## Test plan
- Host write 0xDEADBEEF to 0x04 -> bytes 0x04..0x07 = EF,BE,AD,DE in beats 1-4, `host_ack_o` at cycle 6 only.
- CPU read of 0x04 after above -> `cpu_rdata_o`=0xDEADBEEF with `cpu_ack_o` at cycle 6; `host_rdata_o` unchanged.
- Both request from reset, held -> CPU granted first, host next; grants alternate CPU, host, CPU across three accesses.
- CPU write to address 0x0B -> beats target 0x08..0x0B (low bits ignored).
- `start_i`=0 with CPU req -> no strobe, `busy_o`=0; raise `start_i` -> grant next cycle. Drop `start_i` mid-XFER -> access completes.
- `rst_i` at beat 2 of a write of 0x11223344 to 0x00 -> next cycle IDLE, all outputs reset, no ack; memory 0x00=0x44, 0x01=0x33.
